// File: rtl/ksa_swap_ctrl.sv
// RC4 key-scheduling sequencer: walks s_memory once, swapping s[i] and s[j].
// Define KSA_KEY_LATCH_EN to capture secret_key at start instead of using it live.
module ksa_swap_ctrl #(
    parameter int unsigned RD_WAIT   = 1,
    parameter int unsigned KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    input  logic [7:0]             mem_rdata,
    output logic [7:0]             mem_addr,
    output logic [7:0]             mem_wdata,
    output logic                   mem_wren,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam int unsigned WW = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
    localparam logic [KW-1:0] KIDX_LAST = KW'(KEY_BYTES - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(RD_WAIT - 1);

    typedef enum logic [3:0] {
        StIdle, StRdSi, StWaitSi, StLatchSi, StRdSj, StWaitSj,
        StLatchSj, StWrSi, StWrSj, StNext, StDone
    } state_t;

    state_t              state_q;
    logic [7:0]          i_q;
    logic [7:0]          j_q;
    logic [7:0]          si_q;
    logic [KW-1:0]       kidx_q;
    logic [WW-1:0]       wcnt_q;
    logic [8*KEY_BYTES-1:0] key_src;
    logic [7:0]          key_byte;

`ifdef KSA_KEY_LATCH_EN
    logic [8*KEY_BYTES-1:0] key_q;
    assign key_src = key_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_q <= '0;
        end else if (state_q == StIdle && start) begin
            key_q <= secret_key;
        end
    end
`else
    assign key_src = secret_key;
`endif

    // Byte 0 is the most significant byte of the key.
    always_comb begin
        key_byte = '0;
        for (int unsigned k = 0; k < KEY_BYTES; k++) begin
            if (kidx_q == KW'(k)) begin
                key_byte = key_src[8*(KEY_BYTES-1-k) +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            i_q       <= '0;
            j_q       <= '0;
            si_q      <= '0;
            kidx_q    <= '0;
            wcnt_q    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wren  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            mem_wren <= 1'b0;
            case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        i_q     <= '0;
                        j_q     <= '0;
                        kidx_q  <= '0;
                        busy    <= 1'b1;
                        state_q <= StRdSi;
                    end
                end
                StRdSi: begin
                    mem_addr <= i_q;
                    wcnt_q   <= '0;
                    state_q  <= StWaitSi;
                end
                StWaitSi: begin
                    if (wcnt_q == WAIT_LAST) state_q <= StLatchSi;
                    else wcnt_q <= wcnt_q + 1'b1;
                end
                StLatchSi: begin
                    si_q    <= mem_rdata;
                    j_q     <= j_q + mem_rdata + key_byte;
                    state_q <= StRdSj;
                end
                StRdSj: begin
                    mem_addr <= j_q;
                    wcnt_q   <= '0;
                    state_q  <= StWaitSj;
                end
                StWaitSj: begin
                    if (wcnt_q == WAIT_LAST) state_q <= StLatchSj;
                    else wcnt_q <= wcnt_q + 1'b1;
                end
                // s[j] goes straight into the write-data register for the first write.
                StLatchSj: begin
                    mem_addr  <= i_q;
                    mem_wdata <= mem_rdata;
                    mem_wren  <= 1'b1;
                    state_q   <= StWrSi;
                end
                StWrSi: begin
                    mem_addr  <= j_q;
                    mem_wdata <= si_q;
                    mem_wren  <= 1'b1;
                    state_q   <= StWrSj;
                end
                StWrSj: state_q <= StNext;
                StNext: begin
                    if (i_q == 8'hFF) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        i_q     <= i_q + 8'd1;
                        kidx_q  <= (kidx_q == KIDX_LAST) ? '0 : kidx_q + 1'b1;
                        state_q <= StRdSi;
                    end
                end
                StDone: begin
                    if (!start) begin
                        done    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ksa_swap_ctrl.sv
// Bench for ksa_swap_ctrl: s_memory model, write-trace scoreboard and final-S comparison.
module tb_ksa_swap_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] secret_key = 24'h0;
    logic [7:0]  mem_q;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_wren;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    ksa_swap_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .secret_key (secret_key),
        .mem_rdata  (mem_q),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wren   (mem_wren),
        .busy       (busy),
        .done       (done)
    );

    // s_memory model with registered read address.
    logic [7:0] mem [256];
    logic       preload = 1'b0;

    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 256; k++) mem[k] <= k[7:0];
        end else if (mem_wren) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_q <= mem[mem_addr];
    end

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        log_q[$];
    logic [7:0] exp_s [256];
    int         n_total = 0;
    int         n_pass = 0;
    int         wren_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    always @(negedge clk) begin
        if (mem_wren) begin
            wr_t e;
            wren_cnt++;
            log_q.push_back({mem_addr, mem_wdata});
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write: got addr %0d data %0d, required no write",
                         mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", {24'h0, mem_addr}, {24'h0, e.a});
                check("write_data", {24'h0, mem_wdata}, {24'h0, e.d});
            end
        end
    end

    // Reference KSA; key switches from k0 to k1 at iteration sw.
    task automatic model_push(input logic [23:0] k0, input logic [23:0] k1, input int sw);
        logic [7:0]  s [256];
        logic [7:0]  j, si, sj, kb;
        logic [23:0] key;
        for (int k = 0; k < 256; k++) s[k] = k[7:0];
        j = 8'h0;
        for (int i = 0; i < 256; i++) begin
            key = (i >= sw) ? k1 : k0;
            kb  = key[8*(2-(i%3)) +: 8];
            j   = j + s[i] + kb;
            si  = s[i];
            sj  = s[j];
            exp_q.push_back({i[7:0], sj});
            exp_q.push_back({j, si});
            s[i] = sj;
            s[j] = si;
        end
        for (int k = 0; k < 256; k++) exp_s[k] = s[k];
    endtask

    task automatic do_preload();
        preload = 1'b1;
        @(posedge clk);
        #1;
        preload = 1'b0;
    endtask

    task automatic check_mem(input string name);
        int bad = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== exp_s[k]) bad++;
        check(name, bad, 0);
    endtask

    task automatic check_wr(input string name, input int idx, input logic [7:0] a,
                            input logic [7:0] d);
        if (log_q.size() > idx) begin
            check({name, "_addr"}, {24'h0, log_q[idx].a}, {24'h0, a});
            check({name, "_data"}, {24'h0, log_q[idx].d}, {24'h0, d});
        end else begin
            check({name, "_present"}, log_q.size(), idx + 1);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_addr"}, {24'h0, mem_addr}, 0);
        check({name, "_wdata"}, {24'h0, mem_wdata}, 0);
        check({name, "_wren"}, {31'h0, mem_wren}, 0);
        check({name, "_busy"}, {31'h0, busy}, 0);
        check({name, "_done"}, {31'h0, done}, 0);
    endtask

    // Full pass from IDLE; leaves start high with the DUT in DONE.
    task automatic run_pass(input string tag, input logic [23:0] k0, input logic [23:0] k1,
                            input int sw, input bit do_change);
        int n = 0;
        do_preload();
        log_q.delete();
        wren_cnt = 0;
        model_push(k0, k1, sw);
        secret_key = k0;
        start = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_busy_after_accept"}, {31'h0, busy}, 1);
        while (!done && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
            if (do_change && n == 500) secret_key = k1;
        end
        check({tag, "_done_latency"}, n, 2304);
        check({tag, "_busy_at_done"}, {31'h0, busy}, 0);
        check({tag, "_pending_writes"}, exp_q.size(), 0);
        check({tag, "_wren_count"}, wren_cnt, 512);
        check_mem({tag, "_final_s"});
        exp_q.delete();
    endtask

    task automatic drop_start(input string tag);
        start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_done_cleared"}, {31'h0, done}, 0);
        check({tag, "_busy_idle"}, {31'h0, busy}, 0);
    endtask

    initial begin
        int sw;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Key 0x000249: hand-computed first two iterations.
        run_pass("key249", 24'h000249, 24'h000249, 256, 1'b0);
        check_wr("key249_w0", 0, 8'd0, 8'd0);
        check_wr("key249_w1", 1, 8'd0, 8'd0);
        check_wr("key249_w2", 2, 8'd1, 8'd3);
        check_wr("key249_w3", 3, 8'd3, 8'd1);
        drop_start("key249");

        // Zero key: i=1 gives j=1; then start held through DONE.
        run_pass("key0", 24'h000000, 24'h000000, 256, 1'b0);
        check_wr("key0_w2", 2, 8'd1, 8'd1);
        check_wr("key0_w3", 3, 8'd1, 8'd1);
        repeat (20) @(posedge clk);
        #1;
        check("hold_done", {31'h0, done}, 1);
        check("hold_busy", {31'h0, busy}, 0);
        check("hold_no_writes", wren_cnt, 512);
        drop_start("hold");
        run_pass("rerun", 24'h000249, 24'h000249, 256, 1'b0);
        drop_start("rerun");

        // Reset 1000 cycles into a pass.
        do_preload();
        log_q.delete();
        model_push(24'h000249, 24'h000249, 256);
        secret_key = 24'h000249;
        start = 1'b1;
        @(posedge clk);
        repeat (1000) @(posedge clk);
        #2;
        check("midpass_busy_before", {31'h0, busy}, 1);
        reset_n = 1'b0;
        #1;
        check_idle_outputs("midpass_reset");
        exp_q.delete();
        start = 1'b0;
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_idle_outputs("after_reset");
        run_pass("post_reset", 24'h000249, 24'h000249, 256, 1'b0);
        drop_start("post_reset");

        // Key change after edge 500: LATCH_SI for i=56 is the first to see it (9*56+3 > 500).
`ifdef KSA_KEY_LATCH_EN
        sw = 256;
`else
        sw = 56;
`endif
        run_pass("keychg", 24'h000249, 24'h0003FF, sw, 1'b1);
        drop_start("keychg");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
